// File: rtl/shift_seq_reg.sv
// WIDTH-bit shift register with a multi-cycle sequencer: parallel load in IDLE,
// then a start request shifts the register one bit per clock for `amount` clocks.
module shift_seq_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [AMT_W-1:0] count_reg, count_next;
  logic [1:0]       mode_reg, mode_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             sout_reg, sout_next;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      mode_reg  <= '0;
      data_reg  <= '0;
      sout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      mode_reg  <= mode_next;
      data_reg  <= data_next;
      sout_reg  <= sout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    mode_next  = mode_reg;
    data_next  = data_reg;
    sout_next  = sout_reg;

    unique case (state_reg)
      IDLE: begin
        // Load wins over start; a simultaneous start is dropped.
        if (load_en) begin
          data_next = load_val;
          sout_next = 1'b0;
        end else if (start) begin
          mode_next  = mode;
          count_next = amount;
          state_next = (amount == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        // Mode comes from the latched copy so mid-operation input changes are inert.
        unique case (mode_reg)
          MODE_LSR: begin
            data_next = {serial_in, data_reg[WIDTH-1:1]};
            sout_next = data_reg[0];
          end
          MODE_ASR: begin
            data_next = {data_reg[WIDTH-1], data_reg[WIDTH-1:1]};
            sout_next = data_reg[0];
          end
          MODE_LSL: begin
            data_next = {data_reg[WIDTH-2:0], serial_in};
            sout_next = data_reg[WIDTH-1];
          end
          default: begin
            data_next = {data_reg[0], data_reg[WIDTH-1:1]};
            sout_next = data_reg[0];
          end
        endcase
        count_next = count_reg - 1'b1;
        if (count_reg == AMT_W'(1)) begin
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data_out   = data_reg;
  assign serial_out = sout_reg;
  assign busy       = (state_reg == SHIFT);
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_shift_seq_reg.sv
// Directed bench for shift_seq_reg: loads, shifts in every mode, handshake
// timing, ignored requests and reset abort, against hand-computed values.
module tb_shift_seq_reg;

  logic       clock;
  logic       reset;
  logic       load_en;
  logic [7:0] load_val;
  logic       start;
  logic [1:0] mode;
  logic [3:0] amount;
  logic       serial_in;
  logic [7:0] data_out;
  logic       serial_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  shift_seq_reg #(.WIDTH(8), .AMT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_en    (load_en),
    .load_val   (load_val),
    .start      (start),
    .mode       (mode),
    .amount     (amount),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
      $display("ok   %s: %0h", tag, observed);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clock);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clock);
    load_en  = 1'b0;
  endtask

  // Issue start, count busy cycles, then check result, done pulse width.
  task automatic run_shift(input string tag, input logic [1:0] m, input logic [3:0] a,
                           input logic sin, input logic [7:0] exp_data, input logic exp_sout);
    int busy_cnt;
    @(negedge clock);
    start = 1'b1; mode = m; amount = a; serial_in = sin;
    @(negedge clock);
    start = 1'b0; mode = ~m; amount = ~a;
    busy_cnt = 0;
    while (busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      @(negedge clock);
    end
    check({tag, " busy_cycles"}, busy_cnt, {28'd0, a});
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " data"}, {24'd0, data_out}, {24'd0, exp_data});
    check({tag, " sout"}, {31'd0, serial_out}, {31'd0, exp_sout});
    @(negedge clock);
    check({tag, " done_one_cycle"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int done_seen;
    reset = 1'b0; load_en = 1'b0; load_val = 8'h00; start = 1'b0;
    mode = 2'b00; amount = 4'd0; serial_in = 1'b0;
    repeat (2) @(negedge clock);
    check("reset state", {21'd0, data_out, serial_out, busy, done}, 32'd0);
    reset = 1'b1;

    // Arbitrary activity, then a one-edge reset.
    do_load(8'hA5);
    @(negedge clock); start = 1'b1; mode = 2'b10; amount = 4'd4; serial_in = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    check("reset after activity", {21'd0, data_out, serial_out, busy, done}, 32'd0);

    do_load(8'h96);
    check("load 96", {24'd0, data_out}, 32'h96);
    check("load sout", {31'd0, serial_out}, 32'd0);
    run_shift("ASR3", 2'b01, 4'd3, 1'b0, 8'hF2, 1'b1);

    do_load(8'h96);
    run_shift("LSR2", 2'b00, 4'd2, 1'b1, 8'hE5, 1'b1);
    do_load(8'h96);
    run_shift("LSL1", 2'b10, 4'd1, 1'b0, 8'h2C, 1'b1);
    do_load(8'h96);
    run_shift("ROR8", 2'b11, 4'd8, 1'b0, 8'h96, 1'b1);
    run_shift("AMT0", 2'b00, 4'd0, 1'b1, 8'h96, 1'b1);
    do_load(8'h96);
    run_shift("ASR10", 2'b01, 4'd10, 1'b0, 8'hFF, 1'b1);
    do_load(8'h5A);
    run_shift("LSL15", 2'b10, 4'd15, 1'b1, 8'hFF, 1'b1);

    // load_en and start together: load wins, no operation.
    @(negedge clock);
    load_en = 1'b1; load_val = 8'h3C; start = 1'b1; mode = 2'b11; amount = 4'd2;
    @(negedge clock);
    load_en = 1'b0; start = 1'b0;
    check("load+start data", {24'd0, data_out}, 32'h3C);
    check("load+start busy/done", {30'd0, busy, done}, 32'd0);
    @(negedge clock);
    check("load+start later busy/done", {30'd0, busy, done}, 32'd0);

    // Requests during SHIFT and DONE are ignored.
    @(negedge clock); start = 1'b1; mode = 2'b00; amount = 4'd3; serial_in = 1'b0;
    @(negedge clock);
    load_en = 1'b1; load_val = 8'hFF; mode = 2'b11; amount = 4'd1;
    busy_cnt = 0;
    while (busy === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      @(negedge clock);
    end
    check("ignore busy_cycles", busy_cnt, 32'd3);
    check("ignore done", {31'd0, done}, 32'd1);
    check("ignore data", {24'd0, data_out}, 32'h07);
    check("ignore sout", {31'd0, serial_out}, 32'd1);
    @(negedge clock);
    load_en = 1'b0; start = 1'b0;
    check("ignore in DONE data", {24'd0, data_out}, 32'h07);
    check("ignore in DONE busy", {31'd0, busy}, 32'd0);

    // Reset at the 2nd shift edge of ASR by 5 aborts without done.
    do_load(8'h96);
    @(negedge clock); start = 1'b1; mode = 2'b01; amount = 4'd5;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    check("abort first shift", {24'd0, data_out}, 32'hCB);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("abort state", {21'd0, data_out, serial_out, busy, done}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("abort no done/busy", done_seen, 32'd0);
    check("abort data held", {24'd0, data_out}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
